// File: rtl/ext_gcd_unit.sv
// Iterative subtractive GCD engine for the CPU multicycle controller.
// One rule is applied per CALC cycle; y_bo/steps_bo hold until the next completion.
module ext_gcd_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    output logic             busy_o,
    output logic [WIDTH-1:0] y_bo,
    output logic             done_o,
    output logic [15:0]      steps_bo
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   b_s;
    logic [WIDTH-1:0]   y_s;
    logic [15:0]        cnt_r;
    logic [15:0]        cnt_s;
    logic [15:0]        cnt_inc_s;
    logic [15:0]        steps_s;
    logic               busy_s;
    logic               done_s;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // State register plus every registered datapath value and output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            a_r      <= ZERO_W;
            b_r      <= ZERO_W;
            cnt_r    <= 16'd0;
            y_bo     <= ZERO_W;
            steps_bo <= 16'd0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            cnt_r    <= cnt_s;
            y_bo     <= y_s;
            steps_bo <= steps_s;
            busy_o   <= busy_s;
            done_o   <= done_s;
        end
    end

    // Next-state and datapath rules; the terminating cycle's count is included in steps.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        b_s       = b_r;
        cnt_s     = cnt_r;
        y_s       = y_bo;
        steps_s   = steps_bo;
        busy_s    = busy_o;
        done_s    = 1'b0;
        cnt_inc_s = sat_inc(cnt_r);
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    a_s     = a_bi;
                    b_s     = b_bi;
                    cnt_s   = 16'd0;
                    state_s = ST_CALC;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                cnt_s = cnt_inc_s;
                if (a_r == ZERO_W) begin
                    y_s     = b_r;
                    steps_s = cnt_inc_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (b_r == ZERO_W) begin
                    y_s     = a_r;
                    steps_s = cnt_inc_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (a_r == b_r) begin
                    y_s     = a_r;
                    steps_s = cnt_inc_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (a_r > b_r) begin
                    a_s = a_r - b_r;
                end else begin
                    b_s = b_r - a_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ext_gcd_unit.sv
// Directed plus randomized bench for ext_gcd_unit against a Euclid-by-division reference.
module tb_ext_gcd_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic [7:0]  y;
    logic        done;
    logic [15:0] steps;

    int compared   = 0;
    int mismatched = 0;

    ext_gcd_unit #(.WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .a_bi     (a_in),
        .b_bi     (b_in),
        .busy_o   (busy),
        .y_bo     (y),
        .done_o   (done),
        .steps_bo (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_gcd(input int a, input int b);
        int x;
        int z;
        int t;
        x = a;
        z = b;
        while (z != 0) begin
            t = x % z;
            x = z;
            z = t;
        end
        return x;
    endfunction

    // Subtractive steps equal the sum of Euclid quotients, minus the final one that lands on equality.
    function automatic int ref_subs(input int a, input int b);
        int x;
        int z;
        int t;
        int s;
        if (a == 0 || b == 0) return 0;
        x = a;
        z = b;
        s = 0;
        while (z != 0) begin
            s = s + x / z;
            t = x % z;
            x = z;
            z = t;
        end
        return s - 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one operation and ends on the negedge where busy has just fallen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit no_wait, input bit scramble);
        int busy_cnt;
        int done_cnt;
        int guard;
        int s;
        if (!no_wait) @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        check("done_low_after_capture", int'(done), 0);
        s = ref_subs(a, b);
        busy_cnt = 0;
        done_cnt = 0;
        guard    = 0;
        while (busy === 1'b1 && guard < 2000) begin
            busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (scramble && busy_cnt == 1) begin
                start = 1'b1;
                a_in  = 8'd7;
                b_in  = 8'd7;
            end else if (scramble) begin
                start = 1'b0;
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check("busy_cycles", busy_cnt, s + 1);
        check("done_during_busy", done_cnt, 0);
        check("done_pulse", int'(done), 1);
        check("y", int'(y), ref_gcd(a, b));
        check("steps", int'(steps), s + 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_y", int'(y), 0);
        check("rst_steps", int'(steps), 0);
        rst = 1'b0;

        run_op(8'd12, 8'd18, 1'b0, 1'b0);
        check("y_12_18", int'(y), 6);
        check("steps_12_18", int'(steps), 3);
        @(negedge clk);
        check("done_single", int'(done), 0);

        run_op(8'd0, 8'd0, 1'b0, 1'b0);
        check("y_0_0", int'(y), 0);
        run_op(8'd0, 8'd45, 1'b0, 1'b0);
        check("y_0_45", int'(y), 45);
        check("steps_0_45", int'(steps), 1);

        run_op(8'd255, 8'd1, 1'b0, 1'b0);
        check("steps_255_1", int'(steps), 255);
        run_op(8'd1, 8'd255, 1'b0, 1'b0);
        check("steps_1_255", int'(steps), 255);

        // Start pulses and operand changes mid-computation must not disturb the result.
        run_op(8'd12, 8'd18, 1'b0, 1'b1);
        check("y_scramble", int'(y), 6);
        @(negedge clk);
        check("no_restart_busy", int'(busy), 0);
        @(negedge clk);
        check("no_restart_busy2", int'(busy), 0);
        check("y_hold", int'(y), 6);

        // Reset mid-computation aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd255;
        b_in  = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_y", int'(y), 0);
        check("abort_steps", int'(steps), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        check("abort_idle", int'(busy), 0);
        run_op(8'd9, 8'd6, 1'b0, 1'b0);
        check("y_9_6", int'(y), 3);

        // Back-to-back: second start issued on the cycle busy falls.
        run_op(8'd8, 8'd12, 1'b0, 1'b0);
        check("y_8_12", int'(y), 4);
        run_op(8'd5, 8'd5, 1'b1, 1'b0);
        check("y_5_5", int'(y), 5);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (($urandom % 16) == 0) ra = 8'd0;
            run_op(ra, rb, bit'(i % 2), 1'b0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
